// File: rtl/order_matcher.sv
// order_matcher: single-level limit order book (one bid, one ask) with a
// CHECK/MATCH pipeline and a terminal halt driven by the trade counter.
module order_matcher (
  input  logic       clk,
  input  logic       reset,
  input  logic       order_valid,
  input  logic       order_side,
  input  logic [7:0] order_price,
  input  logic [7:0] order_qty,
  output logic       order_ready,
  input  logic       halt_signal,
  output logic       match_signal,
  output logic [7:0] match_price,
  output logic [7:0] match_qty,
  output logic       enable_count,
  output logic       bid_valid,
  output logic       ask_valid,
  output logic [7:0] book_bid,
  output logic [7:0] book_ask
);
  typedef enum logic [1:0] {IDLE, CHECK, MATCH, HALTED} state_t;
  state_t     r_state;
  logic       r_side, r_halt_pend, r_match;
  logic [7:0] r_price, r_qty, r_mp, r_mq;
  logic       r_bid_v, r_ask_v;
  logic [7:0] r_bid_p, r_bid_q, r_ask_p, r_ask_q;
  logic       w_buy, w_hs, w_cross, w_full, w_better, w_equal, w_keep;
  logic       w_opp_v, w_own_v, w_nopp_v, w_nown_v;
  logic [7:0] w_opp_p, w_opp_q, w_own_p, w_own_q, w_trade, w_resid;
  logic [7:0] w_nopp_p, w_nopp_q, w_nown_p, w_nown_q;
  logic [8:0] w_sum;
  // a halt that arrives with an order is deferred until that order retires
  assign order_ready  = r_state == IDLE && !r_halt_pend && !reset;
  assign enable_count = r_state != HALTED;
  assign w_hs         = order_valid && order_ready;
  assign match_signal = r_match;
  assign match_price  = r_mp;
  assign match_qty    = r_mq;
  assign bid_valid    = r_bid_v;
  assign ask_valid    = r_ask_v;
  assign book_bid     = r_bid_p;
  assign book_ask     = r_ask_p;
  always_comb begin
    w_buy    = !r_side;
    w_opp_v  = w_buy ? r_ask_v : r_bid_v;
    w_opp_p  = w_buy ? r_ask_p : r_bid_p;
    w_opp_q  = w_buy ? r_ask_q : r_bid_q;
    w_own_v  = w_buy ? r_bid_v : r_ask_v;
    w_own_p  = w_buy ? r_bid_p : r_ask_p;
    w_own_q  = w_buy ? r_bid_q : r_ask_q;
    w_cross  = w_opp_v && (w_buy ? r_price >= w_opp_p : r_price <= w_opp_p);
    w_full   = r_qty >= w_opp_q;
    w_trade  = w_full ? w_opp_q : r_qty;
    w_resid  = !w_cross ? r_qty : w_full ? r_qty - w_opp_q : 8'd0;
    w_better = !w_own_v || (w_buy ? r_price > w_own_p : r_price < w_own_p);
    w_equal  = r_price == w_own_p;
    w_sum    = {1'b0, w_own_q} + {1'b0, w_resid};
    w_nopp_v = w_cross && w_full ? 1'b0 : w_opp_v;
    w_nopp_p = w_cross && w_full ? 8'd0 : w_opp_p;
    w_nopp_q = !w_cross ? w_opp_q : w_full ? 8'd0 : w_opp_q - r_qty;
    w_keep   = w_resid == 8'd0 || (!w_better && !w_equal);
    w_nown_v = w_keep ? w_own_v : 1'b1;
    w_nown_p = w_keep ? w_own_p : r_price;
    w_nown_q = w_keep ? w_own_q : w_better ? w_resid : (w_sum[8] ? 8'hff : w_sum[7:0]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_side      <= 1'b0;
      r_price     <= 8'd0;
      r_qty       <= 8'd0;
      r_halt_pend <= 1'b0;
      r_match     <= 1'b0;
      r_mp        <= 8'd0;
      r_mq        <= 8'd0;
      r_bid_v     <= 1'b0;
      r_bid_p     <= 8'd0;
      r_bid_q     <= 8'd0;
      r_ask_v     <= 1'b0;
      r_ask_p     <= 8'd0;
      r_ask_q     <= 8'd0;
    end else begin
      r_match <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_side      <= order_side;
            r_price     <= order_price;
            r_qty       <= order_qty;
            r_halt_pend <= halt_signal;
            r_state     <= CHECK;
          end else if (halt_signal || r_halt_pend) r_state <= HALTED;
        end
        CHECK: begin
          r_state <= IDLE;
          if (r_qty != 8'd0) begin
            if (w_buy) begin
              {r_bid_v, r_bid_p, r_bid_q} <= {w_nown_v, w_nown_p, w_nown_q};
              {r_ask_v, r_ask_p, r_ask_q} <= {w_nopp_v, w_nopp_p, w_nopp_q};
            end else begin
              {r_ask_v, r_ask_p, r_ask_q} <= {w_nown_v, w_nown_p, w_nown_q};
              {r_bid_v, r_bid_p, r_bid_q} <= {w_nopp_v, w_nopp_p, w_nopp_q};
            end
            if (w_cross) begin
              r_match <= 1'b1;
              r_mp    <= w_opp_p;
              r_mq    <= w_trade;
              r_state <= MATCH;
            end
          end
        end
        MATCH:   r_state <= IDLE;
        default: r_state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_order_matcher.sv
// tb_order_matcher: directed vectors against hand-computed book and trade results.
module tb_order_matcher;
  logic       clk = 0, reset = 1;
  logic       order_valid = 0, order_side = 0, halt_signal = 0;
  logic [7:0] order_price = 0, order_qty = 0;
  logic       order_ready, match_signal, enable_count, bid_valid, ask_valid;
  logic [7:0] match_price, match_qty, book_bid, book_ask;
  logic       p_chk, p_mat;
  int         n_chk = 0, n_fail = 0;

  order_matcher dut (
    .clk(clk), .reset(reset), .order_valid(order_valid), .order_side(order_side),
    .order_price(order_price), .order_qty(order_qty), .order_ready(order_ready),
    .halt_signal(halt_signal), .match_signal(match_signal), .match_price(match_price),
    .match_qty(match_qty), .enable_count(enable_count), .bid_valid(bid_valid),
    .ask_valid(ask_valid), .book_bid(book_bid), .book_ask(book_ask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic [7:0] p, input logic [7:0] q, input logic h);
    @(negedge clk);
    order_valid = 1; order_side = s; order_price = p; order_qty = q; halt_signal = h;
    @(negedge clk);
    order_valid = 0; halt_signal = 0;
    p_chk = match_signal;
    @(negedge clk);
    p_mat = match_signal;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ready", order_ready, 0);
    chk("rst_bidv", bid_valid, 0);
    chk("rst_askp", book_ask, 0);
    chk("rst_match", match_signal, 0);
    chk("rst_mq", match_qty, 0);
    reset = 0;
    #1;
    chk("rel_ready", order_ready, 1);
    chk("rel_en", enable_count, 1);

    // sell 100@50 then buy 40@55
    send(1, 50, 100, 0);
    chk("s1_pulse", p_mat, 0);
    chk("s1_askv", ask_valid, 1);
    chk("s1_askp", book_ask, 50);
    send(0, 55, 40, 0);
    chk("b1_early", p_chk, 0);
    chk("b1_pulse", p_mat, 1);
    chk("b1_mp", match_price, 50);
    chk("b1_mq", match_qty, 40);
    chk("b1_bidv", bid_valid, 0);
    chk("b1_askv", ask_valid, 1);
    chk("b1_idle", match_signal, 0);
    send(0, 55, 100, 0);
    chk("b2_mq_rest60", match_qty, 60);
    chk("b2_askv", ask_valid, 0);
    chk("b2_bidv", bid_valid, 1);
    chk("b2_bidp", book_bid, 55);
    send(1, 80, 5, 0);
    chk("hold_mp", match_price, 50);
    chk("hold_mq", match_qty, 60);

    // ask 10@50, buy 25@52 leaves bid 15@52
    do_reset();
    send(1, 50, 10, 0);
    send(0, 52, 25, 0);
    chk("b3_mq", match_qty, 10);
    chk("b3_askv", ask_valid, 0);
    chk("b3_bidv", bid_valid, 1);
    chk("b3_bidp", book_bid, 52);
    send(1, 40, 20, 0);
    chk("s3_mp", match_price, 52);
    chk("s3_mq_bid15", match_qty, 15);
    chk("s3_bidv", bid_valid, 0);
    chk("s3_askp", book_ask, 40);

    // saturating bid, worse-price drop, price improvement
    do_reset();
    send(0, 30, 200, 0);
    send(0, 30, 100, 0);
    chk("sat_pulse", p_mat, 0);
    chk("sat_bidp", book_bid, 30);
    send(0, 29, 5, 0);
    chk("drop_pulse", p_mat, 0);
    chk("drop_bidp", book_bid, 30);
    send(1, 30, 255, 0);
    chk("sat_mq255", match_qty, 255);
    chk("sat_bidv", bid_valid, 0);
    chk("sat_askv", ask_valid, 0);
    send(1, 60, 5, 0);
    send(1, 58, 5, 0);
    chk("better_askp", book_ask, 58);
    send(1, 59, 3, 0);
    chk("worse_askp", book_ask, 58);

    // zero-quantity crossing order
    send(0, 70, 0, 0);
    chk("q0_pulse", p_mat, 0);
    chk("q0_askv", ask_valid, 1);
    chk("q0_askp", book_ask, 58);
    chk("q0_ready", order_ready, 1);
    send(0, 70, 5, 0);
    chk("q0_mq_unch", match_qty, 5);

    // halt arriving with an order: order completes, then halted
    do_reset();
    send(1, 50, 10, 0);
    send(0, 50, 4, 1);
    chk("hh_pulse", p_mat, 1);
    chk("hh_mq", match_qty, 4);
    @(negedge clk);
    chk("hh_en", enable_count, 0);
    chk("hh_ready", order_ready, 0);

    // halt while idle
    do_reset();
    send(1, 50, 10, 0);
    @(negedge clk);
    halt_signal = 1;
    @(negedge clk);
    halt_signal = 0;
    chk("halt_en", enable_count, 0);
    chk("halt_ready", order_ready, 0);
    send(0, 60, 5, 0);
    chk("halt_pulse", p_mat, 0);
    chk("halt_bidv", bid_valid, 0);
    chk("halt_askv", ask_valid, 1);

    // reset during CHECK
    do_reset();
    send(1, 50, 10, 0);
    send(0, 50, 2, 0);
    chk("pre_mp", match_price, 50);
    @(negedge clk);
    order_valid = 1; order_side = 0; order_price = 60; order_qty = 5;
    @(negedge clk);
    order_valid = 0;
    #2 reset = 1;
    #1;
    chk("rc_askv", ask_valid, 0);
    chk("rc_askp", book_ask, 0);
    chk("rc_mp", match_price, 0);
    chk("rc_ready", order_ready, 0);
    @(negedge clk);
    chk("rc_match", match_signal, 0);
    reset = 0;
    @(negedge clk);
    chk("rc_match2", match_signal, 0);
    chk("rc_ready2", order_ready, 1);
    chk("rc_bidv", bid_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/order_matcher.md
ORDER_MATCHER -- requirements
Module: order_matcher

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 order_valid  input  1  incoming order present.
REQ-005 order_side  input  1  0 = buy, 1 = sell.
REQ-006 order_price  input  8  unsigned limit price.
REQ-007 order_qty  input  8  unsigned quantity.
REQ-008 order_ready  output  1  block can accept an order this cycle.
REQ-009 halt_signal  input  1  halt request from the downstream trade counter.
REQ-010 match_signal  output  1  one-cycle pulse per trade, consumed by the counter.
REQ-011 match_price  output  8  price of the last trade.
REQ-012 match_qty  output  8  quantity of the last trade.
REQ-013 enable_count  output  1  counting permitted; drives the counter.
REQ-014 bid_valid, ask_valid  output  1 each  resting order present on that side.
REQ-015 book_bid, book_ask  output  8 each  resting bid/ask price.

Function
REQ-016 Book SHALL hold at most one resting bid and one resting ask; each has valid, price[7:0] and qty[7:0].
REQ-017 FSM SHALL have states IDLE, CHECK, MATCH and HALTED.
REQ-018 order_ready SHALL be 1 only in IDLE.
REQ-019 Handshake SHALL be order_valid && order_ready at a rising edge; that edge latches side/price/qty and moves IDLE to CHECK.
REQ-020 In IDLE with no handshake and halt_signal=1, the next state SHALL be HALTED.
REQ-021 If handshake and halt_signal=1 occur together, the order SHALL be processed first and halt taken on the return to IDLE.
REQ-022 In CHECK, an order with qty=0 SHALL be discarded: no trade, no book change, next state IDLE.
REQ-023 Cross SHALL be: buy with ask_valid and price >= ask price, or sell with bid_valid and price <= bid price (unsigned compare).
REQ-024 Cross in CHECK: trade qty = min(incoming, resting); match_price = resting price; next state MATCH; book updated on the same edge.
REQ-025 If incoming qty >= resting qty, the resting side SHALL be cleared and residual = incoming - resting; otherwise resting qty -= incoming and residual = 0.
REQ-026 Each order SHALL match at most once; residual > 0 rests on its own side.
REQ-027 Residual (or the full qty if no cross) SHALL rest when its side is empty or the price is better (buy higher, sell lower), replacing the old entry.
REQ-028 At equal price, residual qty SHALL be added to the resting qty, saturating at 255.
REQ-029 A residual at a worse price SHALL be dropped.
REQ-030 No cross: next state IDLE, book updated per REQ-027..029.
REQ-031 match_signal SHALL be 1 for exactly the cycle in MATCH, 2 cycles after the handshake edge; MATCH always returns to IDLE.
REQ-032 match_price/match_qty SHALL hold their last trade values until the next trade.
REQ-033 HALTED SHALL be terminal until reset: order_ready=0, enable_count=0, book frozen, no match_signal.
REQ-034 enable_count SHALL be 1 in every state except HALTED.

Reset
REQ-035 Reset SHALL take effect immediately, including mid-order: state IDLE, book cleared (valid=0, price=0, qty=0), match_signal=0, match_price=0, match_qty=0.
REQ-036 During reset, order_ready SHALL be 0; enable_count SHALL be 1 from reset release.
REQ-037 An order latched but unfinished when reset asserts SHALL be lost.

Verification
REQ-038 Sell 100@50, then buy 40@55 -> no pulse for the sell; one pulse 2 cycles after the buy handshake, match_price=50, match_qty=40, ask qty=60, bid_valid=0.
REQ-039 Ask 10@50, then buy 25@52 -> match_qty=10, ask_valid=0, bid_valid=1, book_bid=52, bid qty 15.
REQ-040 Bids 200@30 then 100@30 -> bid qty 255 (saturated); buy 5@29 -> dropped, book unchanged.
REQ-041 halt_signal=1 while idle -> HALTED next cycle, order_ready=0, enable_count=0; further orders ignored until reset.
REQ-042 Reset asserted in CHECK -> outputs and book cleared immediately, no match_signal; after release, order_ready=1.
REQ-043 qty=0 crossing order -> no pulse, book unchanged, back in IDLE after 2 cycles.
